// File: rtl/load_store_unit_pkg.sv
// Shared LSU types: memory access width encoding, FSM state, and funct3 classification helpers.
package LOAD_STORE_FNS;

    localparam int WIDTH = 32;

    typedef enum logic [2:0] {
        BYTE   = 3'b000,
        HALF   = 3'b001,
        WORD   = 3'b010,
        BYTE_U = 3'b100,
        HALF_U = 3'b101
    } funct3_t;

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        WAIT,
        MERGE,
        RESP
    } lsu_state_t;

    function automatic logic f3_legal(input funct3_t f);
        case (f)
            BYTE, HALF, WORD, BYTE_U, HALF_U: f3_legal = 1'b1;
            default:                          f3_legal = 1'b0;
        endcase
    endfunction

    function automatic logic f3_misaligned(input funct3_t f, input logic [1:0] lane);
        case (f)
            HALF, HALF_U: f3_misaligned = lane[0];
            WORD:         f3_misaligned = (lane != 2'b00);
            default:      f3_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake plus word-wide data memory port of the LSU.
// slave = LSU side, master = execute stage / memory side.
interface load_store_unit_if;
    import LOAD_STORE_FNS::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_wren;
    funct3_t           req_funct3;
    logic [WIDTH-1:0]  req_base;
    logic [WIDTH-1:0]  req_offset;
    logic [WIDTH-1:0]  req_wdata;

    logic              resp_valid;
    logic              resp_ready;
    logic [WIDTH-1:0]  resp_data;
    logic              resp_fault;

    logic [WIDTH-1:0]  mem_addr;
    logic              mem_wren;
    logic [WIDTH-1:0]  mem_wr_data;
    funct3_t           mem_funct3;
    logic [WIDTH-1:0]  mem_rd_data;

    modport slave (
        input  req_valid, req_wren, req_funct3, req_base, req_offset, req_wdata,
        output req_ready,
        output resp_valid, resp_data, resp_fault,
        input  resp_ready,
        output mem_addr, mem_wren, mem_wr_data, mem_funct3,
        input  mem_rd_data
    );

    modport master (
        output req_valid, req_wren, req_funct3, req_base, req_offset, req_wdata,
        input  req_ready,
        input  resp_valid, resp_data, resp_fault,
        output resp_ready,
        input  mem_addr, mem_wren, mem_wr_data, mem_funct3,
        output mem_rd_data
    );

endinterface

// File: rtl/load_store_unit_align.sv
// Combinational lane logic: little-endian load extract with sign/zero extension, and
// sub-word store merge into the word read back from memory. No state, no backpressure.
module load_store_align
    import LOAD_STORE_FNS::*;
(
    input  funct3_t           i_funct3,
    input  logic [1:0]        i_lane,
    input  logic [WIDTH-1:0]  i_rd_data,
    input  logic [15:0]       i_wdata,
    output logic [WIDTH-1:0]  o_ld_data,
    output logic [WIDTH-1:0]  o_st_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Halfword lane ignores addr[0]; misaligned halves are either trapped upstream or rounded down.
    assign w_byte = i_rd_data[{i_lane, 3'b000} +: 8];
    assign w_half = i_rd_data[{i_lane[1], 4'b0000} +: 16];

    always_comb begin
        o_ld_data = i_rd_data;
        case (i_funct3)
            BYTE:    o_ld_data = {{24{w_byte[7]}}, w_byte};
            BYTE_U:  o_ld_data = {24'h000000, w_byte};
            HALF:    o_ld_data = {{16{w_half[15]}}, w_half};
            HALF_U:  o_ld_data = {16'h0000, w_half};
            default: o_ld_data = i_rd_data;
        endcase
    end

    always_comb begin
        o_st_data = i_rd_data;
        case (i_funct3)
            BYTE, BYTE_U: o_st_data[{i_lane, 3'b000} +: 8]      = i_wdata[7:0];
            HALF, HALF_U: o_st_data[{i_lane[1], 4'b0000} +: 16] = i_wdata[15:0];
            default:      o_st_data = i_rd_data;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store sequencer: load 3, SW 2, SB/SH (read-modify-write) 4, fault 1 cycles to resp_valid;
// one request in flight, req_ready only in IDLE, response held until resp_ready. Optional LSU_MISALIGN_TRAP_EN.
module load_store_unit
    import LOAD_STORE_FNS::*;
(
    input  logic              clk,
    input  logic              rst,
    load_store_unit_if.slave  bus
);

    lsu_state_t        r_state;
    lsu_state_t        w_next;

    funct3_t           r_f3;
    logic              r_wren;
    logic [1:0]        r_lane;
    logic [15:0]       r_wdata;
    logic [WIDTH-1:0]  r_resp_data;
    logic              r_resp_fault;
    logic [WIDTH-1:0]  r_mem_addr;
    logic              r_mem_wren;
    logic [WIDTH-1:0]  r_mem_wr_data;

    logic [WIDTH-1:0]  w_eff_addr;
    funct3_t           w_f3_norm;
    logic              w_fault;
    logic              w_accept;
    logic [WIDTH-1:0]  w_ld_data;
    logic [WIDTH-1:0]  w_st_data;

    assign w_eff_addr = bus.req_base + bus.req_offset;
    assign w_f3_norm  = f3_legal(bus.req_funct3) ? bus.req_funct3 : WORD;
    assign w_accept   = bus.req_valid && (r_state == IDLE);

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_fault = !f3_legal(bus.req_funct3) || f3_misaligned(bus.req_funct3, w_eff_addr[1:0]);
`else
    assign w_fault = 1'b0;
`endif

    load_store_align u_align (
        .i_funct3  (r_f3),
        .i_lane    (r_lane),
        .i_rd_data (bus.mem_rd_data),
        .i_wdata   (r_wdata),
        .o_ld_data (w_ld_data),
        .o_st_data (w_st_data)
    );

    always_comb begin
        w_next        = r_state;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        case (r_state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) w_next = w_fault ? RESP : ACCESS;
            end
            ACCESS: w_next = (r_wren && r_f3 == WORD) ? RESP : WAIT;
            WAIT:   w_next = r_wren ? MERGE : RESP;
            MERGE:  w_next = RESP;
            RESP: begin
                bus.resp_valid = 1'b1;
                if (bus.resp_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_f3          <= WORD;
            r_wren        <= 1'b0;
            r_lane        <= 2'b00;
            r_wdata       <= 16'h0000;
            r_resp_data   <= '0;
            r_resp_fault  <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wren    <= 1'b0;
            r_mem_wr_data <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_f3         <= w_f3_norm;
                r_wren       <= bus.req_wren;
                r_lane       <= w_eff_addr[1:0];
                r_wdata      <= bus.req_wdata[15:0];
                r_resp_data  <= '0;
                r_resp_fault <= w_fault;
                // Faulting requests never touch the memory port.
                if (!w_fault) begin
                    r_mem_addr <= {w_eff_addr[WIDTH-1:2], 2'b00};
                    r_mem_wren <= bus.req_wren && (w_f3_norm == WORD);
                    if (bus.req_wren && w_f3_norm == WORD) r_mem_wr_data <= bus.req_wdata;
                end
            end else begin
                case (r_state)
                    ACCESS: r_mem_wren <= 1'b0;
                    WAIT: begin
                        if (r_wren) begin
                            r_mem_wren    <= 1'b1;
                            r_mem_wr_data <= w_st_data;
                        end else begin
                            r_resp_data <= w_ld_data;
                        end
                    end
                    MERGE:   r_mem_wren <= 1'b0;
                    default: r_mem_wren <= 1'b0;
                endcase
            end
        end
    end

    assign bus.resp_data   = r_resp_data;
    assign bus.resp_fault  = r_resp_fault;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_wren    = r_mem_wren;
    assign bus.mem_wr_data = r_mem_wr_data;
    assign bus.mem_funct3  = WORD;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboarded bench for load_store_unit with a synchronous word memory model.
// Expected responses are queued by the driver and checked by an independent monitor.
module tb_load_store_unit;
    import LOAD_STORE_FNS::*;

    logic clk = 1'b0;
    logic rst;
    logic preload;
    always #5 clk = ~clk;

    load_store_unit_if bus();

    load_store_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory: address registered by the LSU, read word returned one cycle later.
    logic [31:0] mem [0:255];
    int          cyc = 0;
    int          wr_count = 0;
    logic [31:0] last_wr_data = 32'h0;
    logic [31:0] last_wr_addr = 32'h0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (preload) begin
            mem[64] <= 32'h8899AABB;
            mem[1]  <= 32'hCAFEF00D;
        end else if (bus.mem_wren) begin
            mem[bus.mem_addr[9:2]] <= bus.mem_wr_data;
            wr_count               <= wr_count + 1;
            last_wr_data           <= bus.mem_wr_data;
            last_wr_addr           <= bus.mem_addr;
        end
        bus.mem_rd_data <= mem[bus.mem_addr[9:2]];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic flag_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out or unexpected event", name);
    endtask

    typedef struct {
        string       name;
        logic [31:0] d;
        logic        f;
        int          lat;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   acc_cyc = 0;
    int   resp_cnt = 0;
    bit   in_resp = 1'b0;

    // Monitor: compares the first cycle of each response, then checks it stays stable.
    always @(negedge clk) begin
        if (rst) begin
            in_resp = 1'b0;
        end else begin
            if (bus.req_valid && bus.req_ready) acc_cyc = cyc;
            if (bus.resp_valid) begin
                if (!in_resp) begin
                    if (q.size() == 0) begin
                        flag_fail("unexpected_resp");
                        cur.name = "none"; cur.d = bus.resp_data; cur.f = bus.resp_fault; cur.lat = 0;
                    end else begin
                        cur = q.pop_front();
                        check({cur.name, "_data"},  bus.resp_data, cur.d);
                        check({cur.name, "_fault"}, {31'h0, bus.resp_fault}, {31'h0, cur.f});
                        check({cur.name, "_latency"}, cyc - acc_cyc, cur.lat);
                    end
                    in_resp = 1'b1;
                end else begin
                    check({cur.name, "_hold_data"},  bus.resp_data, cur.d);
                    check({cur.name, "_hold_fault"}, {31'h0, bus.resp_fault}, {31'h0, cur.f});
                    check({cur.name, "_hold_req_ready"}, {31'h0, bus.req_ready}, 32'h0);
                end
                if (bus.resp_ready) begin
                    in_resp = 1'b0;
                    resp_cnt++;
                end
            end
        end
    end

    task automatic do_req(input string name, input logic wren, input logic [2:0] f3,
                          input logic [31:0] base, input logic [31:0] off, input logic [31:0] wdata,
                          input logic [31:0] exp_d, input logic exp_f, input int exp_lat, input int hold);
        exp_t x;
        int   start;
        bit   ok;
        x.name = name; x.d = exp_d; x.f = exp_f; x.lat = exp_lat;
        q.push_back(x);
        start = resp_cnt;
        @(posedge clk); #1;
        bus.resp_ready = (hold == 0);
        bus.req_valid  = 1'b1;
        bus.req_wren   = wren;
        bus.req_funct3 = funct3_t'(f3);
        bus.req_base   = base;
        bus.req_offset = off;
        bus.req_wdata  = wdata;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (bus.req_ready) ok = 1'b1;
        end
        if (!ok) flag_fail({name, "_accept"});
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        if (hold > 0) begin
            ok = 1'b0;
            for (int i = 0; i < 20 && !ok; i++) begin
                @(negedge clk);
                if (bus.resp_valid) ok = 1'b1;
            end
            repeat (hold) @(posedge clk);
            #1 bus.resp_ready = 1'b1;
        end
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            if (resp_cnt != start) ok = 1'b1;
            else @(negedge clk);
        end
        if (!ok) begin
            flag_fail({name, "_resp"});
            q.delete();
        end
        @(posedge clk); #1;
        if (hold > 0) begin
            @(negedge clk);
            check({name, "_ready_after_handshake"}, {31'h0, bus.req_ready}, 32'h1);
        end
    endtask

    int w0;

    initial begin
        rst            = 1'b1;
        preload        = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_wren   = 1'b0;
        bus.req_funct3 = WORD;
        bus.req_base   = 32'h0;
        bus.req_offset = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 preload = 1'b0;
        @(negedge clk);
        check("rst_req_ready",   {31'h0, bus.req_ready},  32'h1);
        check("rst_resp_valid",  {31'h0, bus.resp_valid}, 32'h0);
        check("rst_resp_data",   bus.resp_data,           32'h0);
        check("rst_resp_fault",  {31'h0, bus.resp_fault}, 32'h0);
        check("rst_mem_addr",    bus.mem_addr,            32'h0);
        check("rst_mem_wren",    {31'h0, bus.mem_wren},   32'h0);
        check("rst_mem_wr_data", bus.mem_wr_data,         32'h0);
        @(posedge clk); #1 rst = 1'b0;

        // Loads from word 0x100 = 0x8899AABB
        do_req("lb_103",  1'b0, 3'b000, 32'h100, 32'h3, 32'h0, 32'hFFFFFF88, 1'b0, 3, 0);
        do_req("lbu_103", 1'b0, 3'b100, 32'h100, 32'h3, 32'h0, 32'h00000088, 1'b0, 3, 0);
        do_req("lhu_102", 1'b0, 3'b101, 32'h100, 32'h2, 32'h0, 32'h00008899, 1'b0, 3, 0);
        do_req("lh_102",  1'b0, 3'b001, 32'h100, 32'h2, 32'h0, 32'hFFFF8899, 1'b0, 3, 0);
        do_req("lb_100",  1'b0, 3'b000, 32'h100, 32'h0, 32'h0, 32'hFFFFFFBB, 1'b0, 3, 0);
        do_req("lbu_101", 1'b0, 3'b100, 32'h100, 32'h1, 32'h0, 32'h000000AA, 1'b0, 3, 0);
        do_req("lw_100",  1'b0, 3'b010, 32'h100, 32'h0, 32'h0, 32'h8899AABB, 1'b0, 3, 0);

        // Misaligned and illegal accesses
        w0 = wr_count;
`ifdef LSU_MISALIGN_TRAP_EN
        do_req("lh_101",  1'b0, 3'b001, 32'h100, 32'h1, 32'h0, 32'h0, 1'b1, 1, 0);
        do_req("f3_011",  1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 32'h0, 1'b1, 1, 0);
        do_req("lw_102",  1'b0, 3'b010, 32'h100, 32'h2, 32'h0, 32'h0, 1'b1, 1, 0);
        do_req("sw_101",  1'b1, 3'b010, 32'h100, 32'h1, 32'h55555555, 32'h0, 1'b1, 1, 0);
`else
        do_req("lh_101",  1'b0, 3'b001, 32'h100, 32'h1, 32'h0, 32'hFFFFAABB, 1'b0, 3, 0);
        do_req("f3_011",  1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 32'h8899AABB, 1'b0, 3, 0);
        do_req("lw_102",  1'b0, 3'b010, 32'h100, 32'h2, 32'h0, 32'h8899AABB, 1'b0, 3, 0);
`endif
        check("no_write_on_loads_faults", wr_count - w0, 0);
        check("word_100_untouched", mem[64], 32'h8899AABB);

        // Sub-word stores are read-modify-write with a single write pulse
        w0 = wr_count;
        do_req("sb_101", 1'b1, 3'b000, 32'h100, 32'h1, 32'h12345655, 32'h0, 1'b0, 4, 0);
        check("sb_write_count", wr_count - w0, 1);
        check("sb_write_data",  last_wr_data, 32'h889955BB);
        check("sb_write_addr",  last_wr_addr, 32'h00000100);
        do_req("lw_after_sb", 1'b0, 3'b010, 32'h100, 32'h0, 32'h0, 32'h889955BB, 1'b0, 3, 0);

        w0 = wr_count;
        do_req("sh_102", 1'b1, 3'b001, 32'h100, 32'h2, 32'hABCD1234, 32'h0, 1'b0, 4, 0);
        check("sh_write_count", wr_count - w0, 1);
        check("sh_write_data",  last_wr_data, 32'h123455BB);

        w0 = wr_count;
        do_req("sw_104", 1'b1, 3'b010, 32'h108, 32'hFFFFFFFC, 32'hDEADBEEF, 32'h0, 1'b0, 2, 0);
        check("sw_write_count", wr_count - w0, 1);
        check("sw_write_addr",  last_wr_addr, 32'h00000104);
        do_req("lw_104", 1'b0, 3'b010, 32'h104, 32'h0, 32'h0, 32'hDEADBEEF, 1'b0, 3, 0);

        // Address wraps modulo 2^32
        do_req("lw_wrap", 1'b0, 3'b010, 32'hFFFFFFFC, 32'h8, 32'h0, 32'hCAFEF00D, 1'b0, 3, 0);
        check("wrap_mem_addr", bus.mem_addr, 32'h00000004);

        // Response backpressure for 5 cycles
        do_req("lw_hold", 1'b0, 3'b010, 32'h100, 32'h0, 32'h0, 32'h123455BB, 1'b0, 3, 5);

        // Reset while an SH sits in WAIT: no write may reach memory
        w0 = wr_count;
        @(posedge clk); #1;
        bus.req_valid  = 1'b1;
        bus.req_wren   = 1'b1;
        bus.req_funct3 = HALF;
        bus.req_base   = 32'h100;
        bus.req_offset = 32'h0;
        bus.req_wdata  = 32'h00007777;
        @(posedge clk); #1 bus.req_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rst_wait_req_ready",  {31'h0, bus.req_ready},  32'h1);
        check("rst_wait_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
        check("rst_wait_mem_wren",   {31'h0, bus.mem_wren},   32'h0);
        repeat (4) @(posedge clk);
        #1;
        check("rst_wait_no_write", wr_count - w0, 0);
        check("rst_wait_word",     mem[64], 32'h123455BB);
        do_req("lw_after_rst", 1'b0, 3'b010, 32'h100, 32'h0, 32'h0, 32'h123455BB, 1'b0, 3, 0);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
